// File: rtl/pov_lsr_bank.sv
// pov_lsr_bank: CH-channel WIDTH-bit load/shift register bank for the POV LED
// column driver. Manual load/shift in IDLE, or a paced autonomous burst of
// WIDTH shifts (one every DIV cycles) with busy/done handshake.
// Optional feature macro: LSR_ROTATE_EN (circular rotate instead of zero fill).
module pov_lsr_bank #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned CH    = 3,
    parameter int unsigned DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load,
    input  logic                  shift,
    input  logic                  dir,
    input  logic                  rotate,
    input  logic [CH*WIDTH-1:0]   pattern,
    output logic [CH*WIDTH-1:0]   out,
    output logic [CH-1:0]         lsb,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SW = ($clog2(WIDTH + 1) > 0) ? $clog2(WIDTH + 1) : 1;
    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [SW-1:0]         step_q, step_d;
    logic [DW-1:0]         div_q, div_d;
    logic                  dir_q, dir_d;
    logic [CH*WIDTH-1:0]   regs_d;
    logic                  busy_d, done_d;
    logic                  rot_live, rot_run;

`ifdef LSR_ROTATE_EN
    logic rot_q, rot_d;
    assign rot_live = rotate;
    assign rot_run  = rot_q;
`else
    // rotate kept only for pin compatibility; fill is always zero
    logic unused_rotate;
    assign unused_rotate = rotate;
    assign rot_live      = 1'b0;
    assign rot_run       = 1'b0;
`endif

    // Shift every channel one place; rot selects circular vs zero fill
    function automatic logic [CH*WIDTH-1:0] shift_all(
        input logic [CH*WIDTH-1:0] r,
        input logic                d,
        input logic                rot
    );
        logic [CH*WIDTH-1:0] res;
        logic [WIDTH-1:0]    ch;
        res = '0;
        for (int k = 0; k < int'(CH); k++) begin
            ch = r[k*WIDTH +: WIDTH];
            if (d) ch = {ch[WIDTH-2:0], rot & ch[WIDTH-1]};
            else   ch = {rot & ch[0], ch[WIDTH-1:1]};
            res[k*WIDTH +: WIDTH] = ch;
        end
        return res;
    endfunction

    // Next-state and datapath decode
    always_comb begin
        state_d = state_q;
        regs_d  = out;
        step_d  = step_q;
        div_d   = div_q;
        dir_d   = dir_q;
`ifdef LSR_ROTATE_EN
        rot_d   = rot_q;
`endif
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    regs_d  = pattern;
                    dir_d   = dir;
`ifdef LSR_ROTATE_EN
                    rot_d   = rotate;
`endif
                    step_d  = '0;
                    div_d   = '0;
                    state_d = RUN;
                end else if (load) begin
                    regs_d = pattern;
                end else if (shift) begin
                    regs_d = shift_all(out, dir, rot_live);
                end
            end
            RUN: begin
                if (div_q == DW'(DIV - 1)) begin
                    div_d  = '0;
                    regs_d = shift_all(out, dir_q, rot_run);
                    step_d = step_q + SW'(1);
                    if (step_q == SW'(WIDTH - 1)) state_d = DONE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Exit bit per channel; direction follows the live input only when idle
    always_comb begin
        logic dir_sel;
        dir_sel = (state_q == IDLE) ? dir : dir_q;
        lsb     = '0;
        for (int k = 0; k < int'(CH); k++) begin
            lsb[k] = dir_sel ? out[k*WIDTH + WIDTH - 1] : out[k*WIDTH];
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out     <= '0;
            step_q  <= '0;
            div_q   <= '0;
            dir_q   <= 1'b0;
`ifdef LSR_ROTATE_EN
            rot_q   <= 1'b0;
`endif
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            out     <= regs_d;
            step_q  <= step_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
`ifdef LSR_ROTATE_EN
            rot_q   <= rot_d;
`endif
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: doc/pov_lsr_bank.md
# pov_lsr_bank

Multi-channel parametrised load/shift register bank for the POV LED column driver. Each of CH channels holds a WIDTH-bit pattern that is loaded in parallel and shifted out one bit per step. Shifting runs either by manual single-step control or as an autonomous paced burst with busy/done handshake. The bank sits between the pattern source and the per-colour LED serialisers; it generalises the single-channel, fixed-pattern, right-shift-only register.

## Interface
- WIDTH, 5: bits per channel register (>= 2).
- CH, 3: number of channels (R, G, B by default).
- DIV, 4: clock cycles per shift step in burst mode (>= 1).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start a burst: load pattern, then shift WIDTH times automatically.
- load  in  1  manual parallel load (IDLE only).
- shift  in  1  manual single shift (IDLE only).
- dir  in  1  0 = shift right (toward bit 0), 1 = shift left.
- rotate  in  1  0 = zero-fill, 1 = circular rotate (see Configuration).
- pattern  in  CH*WIDTH  load value; channel k at [k*WIDTH +: WIDTH].
- out  out  CH*WIDTH  current register contents, same packing.
- lsb  out  CH  per-channel exit bit: bit 0 when dir=0, bit WIDTH-1 when dir=1.
- busy  out  1  high while burst is shifting.
- done  out  1  one-cycle pulse at end of burst.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, priority start > load > shift:
  - start: regs <= pattern; latch dir and rotate into dir_q/rot_q; step counter and divider <= 0; -> RUN.
  - load: regs <= pattern; stay IDLE.
  - shift: every channel shifts one place using live dir/rotate; stay IDLE.
  - none: hold.
- RUN: divider counts 0..DIV-1; at DIV-1 all channels shift one place using dir_q/rot_q, divider <= 0, step counter++. The shift that brings the counter to WIDTH -> DONE.
- DONE: one cycle, -> IDLE.
- start, load, shift are ignored in RUN and DONE; dir/rotate changes during RUN have no effect.
- Right shift: {fill, r[WIDTH-1:1]}; left shift: {r[WIDTH-2:0], fill}. fill = 0, or the exiting bit when rotating.
- lsb selects exit bit by live dir in IDLE, by dir_q in RUN/DONE.
- Counters sized $clog2(WIDTH+1) and $clog2(DIV), minimum 1 bit; no wrap beyond stated ranges.

## Timing
- Reset: regs = 0, out = 0, lsb = 0, busy = 0, done = 0, state IDLE, counters 0. rst overrides every other input, including mid-burst (burst aborted, no done).
- out/busy/done are registered; lsb is combinational from regs and direction.
- start sampled at edge T0: out = pattern from T0, busy = 1 from T0.
- Shift n (1..WIDTH) at edge T0 + n*DIV.
- busy falls and done rises at T0 + WIDTH*DIV; done falls at T0 + WIDTH*DIV + 1; new start accepted from that edge.
- Manual load/shift take effect at the sampling edge; one shift per cycle shift is high.

## Configuration
- LSR_ROTATE_EN defined: rotate input honoured as above.
- Undefined: rotate ignored, fill always 0; rotate port still present for pin compatibility; no rot_q register.

## Test plan
- Reset: drive rst with start/load high -> out = 0, busy = 0, done = 0; after release, state IDLE.
- Manual: pattern ch0 = 5'b10000, load, then 4 shifts dir=0 -> ch0 = 00001, lsb[0] = 1; 5th shift -> 00000, lsb[0] = 0.
- Burst WIDTH=5, DIV=4, ch0 = 10000, ch1 = 00011, ch2 = 10101, dir=0 -> busy high 20 cycles, shifts at T0+4,8,12,16,20, all channels 00000, one-cycle done at T0+20.
- Rotate (LSR_ROTATE_EN): burst dir=1, rotate=1, ch2 = 10011 -> after each step 00111, 01110, 11100, 11001, 10011; final equals pattern; without macro final = 00000.
- Ignored inputs: during RUN pulse start, load, shift and toggle dir -> sequence and done time unchanged.
- Abort: rst at T0+10 of a burst -> next cycle out = 0, busy = 0, no done; fresh start then completes normally.
